wr_enable_arb16: RTL and testbench
==================================

# wr_enable_arb16

Upstream write-enable arbiter for the 16-enable, 1-bit output register stage. Captures single-cycle write requests from up to 16 sources, each with its own data bit, and holds each one as pending. Issues at most one request per cycle to the register stage, with round-robin fairness. Drives a registered one-hot enable vector and the matching data bit, so the register stage never sees two enables in the same cycle.

## Interface
- N, 16, number of request sources and enable outputs; legal range 2..16
- PW, $clog2(N), width of the round-robin pointer; derived, not overridden
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  per-source write request, sampled each rising edge
- req_d  input  N  per-source data bit, valid when the matching req bit is 1
- hold  input  1  stall from downstream; no grant is issued while 1
- en  output  N  registered one-hot enable to the register stage; all-zero when idle
- d_out  output  1  registered data bit accompanying en
- pending  output  N  current pending-request mask
- busy  output  1  OR of pending
- ovf  output  1  sticky overflow flag; present only with WRARB_OVF_FLAG_EN
- One clock; reset is asynchronous and active-low (clk, rst_n)

## Operation
- State per source i:
  - pending[i] (1 bit)
  - data[i] (1 bit)
- Global state: round-robin pointer ptr (PW bits).
- Capture, every edge:
  - If req[i]=1, then pending[i] is set to 1 and data[i] takes req_d[i].
  - If pending[i] was already 1 and source i is not granted this cycle, the new data overwrites the old data (last-write-wins).
- Select, combinational from registered state:
  - sel = first index at or after ptr, scanning upward and wrapping N-1 to 0, for which pending=1.
  - Requests arriving in the current cycle are not visible to select.
- Grant, when hold=0 and pending≠0:
  - en is registered as onehot(sel) and d_out as data[sel].
  - pending[sel] is cleared.
  - ptr is set to (sel+1) mod N; wraps from N-1 to 0.
- Simultaneous grant and new request on the same source i:
  - The grant uses the old data[i].
  - pending[i] stays 1, holding the new req_d[i].
- No grant (hold=1 or pending=0):
  - en becomes all-zero; d_out keeps its value.
  - ptr and pending are unchanged, except for new captures.
- busy is the OR of registered pending.

## Timing
- Reset, asynchronous and immediate: en=0, d_out=0, pending=0, data=0, ptr=0, busy=0, ovf=0.
- Release of rst_n is sampled at the next rising edge.
- Latency:
  - Request sampled at edge E0 gives en high after edge E1 at the earliest, for exactly one cycle.
  - Minimum latency is 1 cycle from capture to enable.
- Throughput: one grant per cycle; N simultaneous requests drain in N consecutive cycles.
- en is never more than one-hot, and is held low for one cycle after any hold cycle.
- hold takes effect at the edge where it is sampled; the grant that was already registered is not retracted.
- Reset asserted mid-drain discards all pending requests; no enable is produced for them.

## Configuration
- WRARB_OVF_FLAG_EN defined:
  - ovf is set when req[i]=1 arrives while pending[i]=1 and i is not granted in that cycle.
  - ovf stays 1 until reset.
- WRARB_OVF_FLAG_EN undefined:
  - The ovf port and its logic are absent.
  - Overwrite behaviour is unchanged.

## Test plan
- Reset check:
  - Stimulus: drive rst_n=0 mid-run with pending=16'hFFFF.
  - Required: en=0, d_out=0, pending=0 and busy=0 immediately; after release with no req, en stays 0.
- Single request:
  - Stimulus: req=16'h0008, req_d=16'h0008 for one cycle.
  - Required: pending=16'h0008 the next cycle; en=16'h0008 with d_out=1 the cycle after; pending returns to 0.
- All-source drain from reset:
  - Stimulus: req=16'hFFFF, req_d=16'hAAAA for one cycle.
  - Required: en=0x0001, 0x0002, … 0x8000 on 16 consecutive cycles; d_out alternates 0,1,0,1…; busy falls after the last grant.
- Wrap-around:
  - Stimulus: leave ptr at 14, then req=16'h4003.
  - Required: grants in order 14, 0, 1.
- hold:
  - Stimulus: hold=1 for 3 cycles with 2 requests pending.
  - Required: en=0 throughout; grants resume the cycle after hold drops, in the same order.
- Collision and overflow:
  - Stimulus: re-request source 5 with req_d=0 while it is pending with data 1 and not granted.
  - Required: the later grant carries d_out=0; with WRARB_OVF_FLAG_EN, ovf=1 from the next cycle.
  - Stimulus: re-request source 5 on its own grant cycle.
  - Required: a second grant of source 5 follows, with ovf unchanged.

Source files
------------

// File: rtl/wr_enable_arb16.sv
// wr_enable_arb16: round-robin write-enable arbiter for a 16-enable register stage.
// Single-cycle requests become pending, and at most one pending request is issued
// per cycle as a registered one-hot enable together with its data bit.
// Optional feature: define WRARB_OVF_FLAG_EN to add the sticky ovf output.
module wr_enable_arb16 #(
  parameter  int unsigned N  = 16,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] req_d,
  input  logic         hold,
  output logic [N-1:0] en,
  output logic         d_out,
  output logic [N-1:0] pending,
  output logic         busy
`ifdef WRARB_OVF_FLAG_EN
  ,
  output logic         ovf
`endif
);

  logic [N-1:0]  data_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] sel;
  logic          sel_vld;
  logic          grant;
  logic [N-1:0]  gnt_vec;
  logic [PW-1:0] ptr_nxt;

  // Find the first pending source at or after ptr, wrapping from N-1 back to 0.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!sel_vld && pending[PW'(idx)]) begin
        sel     = PW'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  // Grant decision, one-hot grant vector and the pointer that follows the winner.
  always_comb begin
    grant   = sel_vld & ~hold;
    gnt_vec = grant ? (N'(1) << sel) : '0;
    ptr_nxt = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
  end

  // Pending/data capture, registered enable and data, and pointer update.
  // A new request on the granted source keeps it pending with the new data,
  // while the grant itself reads the data that was stored before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
      en      <= '0;
      d_out   <= 1'b0;
    end else begin
      pending <= req | (pending & ~gnt_vec);
      data_q  <= (req & req_d) | (~req & data_q);
      en      <= gnt_vec;
      if (grant) begin
        d_out <= data_q[sel];
        ptr_q <= ptr_nxt;
      end
    end
  end

  // Busy reflects the registered pending mask.
  always_comb begin
    busy = |pending;
  end

`ifdef WRARB_OVF_FLAG_EN
  // Sticky flag: a request landed on a source that was pending and not granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (|(req & pending & ~gnt_vec)) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wr_enable_arb16.sv
// Testbench for wr_enable_arb16: directed scenarios plus randomized traffic,
// all checked against a behavioural model of pending requests and fairness pointer.
module tb_wr_enable_arb16;
  localparam int unsigned N = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] req_d = '0;
  logic         hold  = 1'b0;
  logic [N-1:0] en;
  logic         d_out;
  logic [N-1:0] pending;
  logic         busy;
`ifdef WRARB_OVF_FLAG_EN
  logic         ovf;
`endif

  wr_enable_arb16 #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_d   (req_d),
    .hold    (hold),
    .en      (en),
    .d_out   (d_out),
    .pending (pending),
    .busy    (busy)
`ifdef WRARB_OVF_FLAG_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [N-1:0] m_pend;
  logic [N-1:0] m_dat;
  int           m_ptr;
  logic [N-1:0] m_en;
  logic         m_dout;
  logic         m_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_dat  = '0;
    m_ptr  = 0;
    m_en   = '0;
    m_dout = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the arbiter as seen from the outside.
  task automatic model_step();
    int g;
    g = -1;
    if (!hold) begin
      for (int off = 0; off < N; off++) begin
        int i;
        i = (m_ptr + off) % N;
        if (g < 0 && m_pend[i]) g = i;
      end
    end
    for (int i = 0; i < N; i++)
      if (req[i] && m_pend[i] && i != g) m_ovf = 1'b1;
    if (g >= 0) begin
      m_en      = N'(1) << g;
      m_dout    = m_dat[g];
      m_pend[g] = 1'b0;
      m_ptr     = (g + 1) % N;
    end else begin
      m_en = '0;
    end
    for (int i = 0; i < N; i++)
      if (req[i]) begin
        m_pend[i] = 1'b1;
        m_dat[i]  = req_d[i];
      end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".en"}, 32'(en), 32'(m_en));
    check_val({tag, ".d_out"}, 32'(d_out), 32'(m_dout));
    check_val({tag, ".pending"}, 32'(pending), 32'(m_pend));
    check_val({tag, ".busy"}, 32'(busy), 32'(|m_pend));
    check_val({tag, ".onehot"}, 32'($onehot0(en)), 32'd1);
`ifdef WRARB_OVF_FLAG_EN
    check_val({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
`endif
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] rd, input logic h);
    @(negedge clk);
    req   = r;
    req_d = rd;
    hold  = h;
    @(posedge clk);
    model_step();
    #1;
    check_outputs("step");
  endtask

  // Asynchronous reset asserted between edges, released on a falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst");
    check_val("rst.en0", 32'(en), 32'd0);
    check_val("rst.pend0", 32'(pending), 32'd0);
    @(negedge clk);
    req   = '0;
    req_d = '0;
    hold  = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    check_outputs("rst_rel");
  endtask

  initial begin
    model_reset();
    #3;
    check_outputs("init");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    check_outputs("init_rel");

    // Single request on source 3
    step(16'h0008, 16'h0008, 1'b0);
    check_val("single.pend", 32'(pending), 32'h0008);
    check_val("single.en_early", 32'(en), 32'h0);
    step('0, '0, 1'b0);
    check_val("single.en", 32'(en), 32'h0008);
    check_val("single.d", 32'(d_out), 32'd1);
    check_val("single.pend_clr", 32'(pending), 32'h0);

    // Mid-run reset with every source pending
    step(16'hFFFF, 16'h1234, 1'b1);
    check_val("fill.pend", 32'(pending), 32'hFFFF);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step('0, '0, 1'b0);
      check_val("post_rst.en", 32'(en), 32'h0);
    end

    // Full drain from the reset pointer
    step(16'hFFFF, 16'hAAAA, 1'b0);
    for (int k = 0; k < 16; k++) begin
      step('0, '0, 1'b0);
      check_val("drain.en", 32'(en), 32'(16'h1 << k));
      check_val("drain.d", 32'(d_out), 32'(k % 2));
    end
    check_val("drain.busy", 32'(busy), 32'd0);

    // Park the pointer at 14, then check wrap-around order 14, 0, 1
    step(16'h2000, '0, 1'b0);
    step('0, '0, 1'b0);
    check_val("park.en", 32'(en), 32'h2000);
    step(16'h4003, 16'hFFFF, 1'b0);
    step('0, '0, 1'b0);
    check_val("wrap.g14", 32'(en), 32'h4000);
    step('0, '0, 1'b0);
    check_val("wrap.g0", 32'(en), 32'h0001);
    step('0, '0, 1'b0);
    check_val("wrap.g1", 32'(en), 32'h0002);

    // Stall for three cycles with sources 5 and 8 pending
    step(16'h0120, 16'h0120, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step('0, '0, 1'b1);
      check_val("hold.en", 32'(en), 32'h0);
    end
    step('0, '0, 1'b0);
    check_val("hold.g5", 32'(en), 32'h0020);
    step('0, '0, 1'b0);
    check_val("hold.g8", 32'(en), 32'h0100);

    // Overwrite of a pending, ungranted source
    step(16'h0020, 16'h0020, 1'b1);
    step(16'h0020, 16'h0000, 1'b1);
    step('0, '0, 1'b0);
    check_val("ovw.en", 32'(en), 32'h0020);
    check_val("ovw.d", 32'(d_out), 32'd0);

    // Re-request on the source's own grant cycle
    step(16'h0020, 16'h0020, 1'b0);
    step(16'h0020, 16'h0000, 1'b0);
    check_val("self.en", 32'(en), 32'h0020);
    check_val("self.d_old", 32'(d_out), 32'd1);
    check_val("self.pend", 32'(pending), 32'h0020);
    step('0, '0, 1'b0);
    check_val("self.en2", 32'(en), 32'h0020);
    check_val("self.d_new", 32'(d_out), 32'd0);

    // Randomized traffic with sparse requests, random stalls and occasional reset
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(N'($urandom & $urandom), N'($urandom), ($urandom_range(0, 3) == 0));
      end
    end

    @(negedge clk);
    req  = '0;
    hold = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
